// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock)
// with start/busy/done handshake, signed input, overflow flag and leading-zero mask.
module bcd_convert_seq #(
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned DIGITS   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   num,
  input  logic                  signed_en,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  overflow,
  output logic [DIGITS-1:0]     lz_mask,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(IN_WIDTH + 1);
  localparam logic [IN_WIDTH-1:0] ONE = IN_WIDTH'(1);
  localparam logic [DIGITS-1:0] LZ_RST = DIGITS'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] mag;
  logic [BW-1:0]       work;
  logic [CW-1:0]       cnt;
  logic                ovf_sticky;
  logic                neg_pending;

  logic [BW-1:0]       adj;
  logic [BW-1:0]       next_work;
  logic                carry_out;
  logic [DIGITS-1:0]   next_lz;
  logic                take_neg;
  logic [3:0]          d;
  logic                any_nz;

  // Add-3 correction, one-bit shift and leading-zero mask of the shifted digits
  always_comb begin
    adj       = '0;
    d         = '0;
    any_nz    = 1'b0;
    next_lz   = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      d = work[4*k +: 4];
      adj[4*k +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
    carry_out = adj[BW-1];
    next_work = {adj[BW-2:0], mag[IN_WIDTH-1]};
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      any_nz     = any_nz | (|next_work[4*k +: 4]);
      next_lz[k] = any_nz;
    end
    next_lz[0] = 1'b1;
    take_neg   = signed_en & num[IN_WIDTH-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mag         <= '0;
      work        <= '0;
      cnt         <= '0;
      ovf_sticky  <= 1'b0;
      neg_pending <= 1'b0;
      bcd         <= '0;
      neg         <= 1'b0;
      overflow    <= 1'b0;
      lz_mask     <= LZ_RST;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag         <= take_neg ? (~num + ONE) : num;
            neg_pending <= take_neg;
            work        <= '0;
            ovf_sticky  <= 1'b0;
            cnt         <= CW'(IN_WIDTH);
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          work       <= next_work;
          mag        <= mag << 1;
          ovf_sticky <= ovf_sticky | carry_out;
          cnt        <= cnt - CW'(1);
          // Last iteration publishes everything together with done
          if (cnt == CW'(1)) begin
            bcd      <= next_work;
            neg      <= neg_pending;
            overflow <= ovf_sticky | carry_out;
            lz_mask  <= next_lz;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
